// File: rtl/ioctl_upload_server.sv
// HPS upload (save) server: pauses the core, then returns core RAM bytes on the ioctl bus.
// Optional two's-complement checksum at address SIZE when UPLOAD_CKSUM_EN is defined.
module ioctl_upload_server #(
    parameter logic [7:0] INDEX   = 8'd4,
    parameter int         AW      = 10,
    parameter int         SIZE    = 1024,
    parameter int         RAM_LAT = 2,
    parameter logic [7:0] FILL    = 8'hFF
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ioctl_upload,
    input  logic [7:0]    ioctl_index,
    input  logic [24:0]   ioctl_addr,
    input  logic          ioctl_rd,
    output logic [7:0]    ioctl_din,
    output logic          ioctl_wait,
    output logic          pause_req,
    input  logic          pause_ack,
    output logic [AW-1:0] ram_addr,
    output logic          ram_rd,
    input  logic [7:0]    ram_q,
    output logic          busy
);

    localparam int          CW     = $clog2(RAM_LAT + 1);
    localparam logic [24:0] SIZE_A = 25'(SIZE);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HOLD    = 3'd1,
        ST_READY   = 3'd2,
        ST_FETCH   = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    state_t        state_r;
    logic [CW-1:0] cnt_r;
    logic          sel_s;
    logic          in_range_s;
    logic [7:0]    oob_byte_s;

`ifdef UPLOAD_CKSUM_EN
    logic [7:0] sum_r;

    function automatic logic [7:0] twos_cksum_f(input logic [7:0] s);
        return (~s) + 8'd1;
    endfunction
`endif

    // Session select and address classification of the current request.
    always_comb begin
        sel_s      = 1'b0;
        in_range_s = 1'b0;
        if (ioctl_upload && (ioctl_index == INDEX)) begin
            sel_s = 1'b1;
        end else begin
            sel_s = 1'b0;
        end
        if (ioctl_addr < SIZE_A) begin
            in_range_s = 1'b1;
        end else begin
            in_range_s = 1'b0;
        end
    end

    // Byte answered for requests beyond the RAM image.
    always_comb begin
        oob_byte_s = FILL;
`ifdef UPLOAD_CKSUM_EN
        if (ioctl_addr == SIZE_A) begin
            oob_byte_s = twos_cksum_f(sum_r);
        end else begin
            oob_byte_s = FILL;
        end
`endif
    end

    // Session FSM; every output is a register updated here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {CW{1'b0}};
            ioctl_din  <= 8'h00;
            ioctl_wait <= 1'b0;
            pause_req  <= 1'b0;
            ram_addr   <= {AW{1'b0}};
            ram_rd     <= 1'b0;
            busy       <= 1'b0;
`ifdef UPLOAD_CKSUM_EN
            sum_r      <= 8'h00;
`endif
        end else begin
            ram_rd <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (sel_s) begin
                        state_r    <= ST_HOLD;
                        pause_req  <= 1'b1;
                        ioctl_wait <= 1'b1;
                        busy       <= 1'b1;
`ifdef UPLOAD_CKSUM_EN
                        sum_r      <= 8'h00;
`endif
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (!sel_s) begin
                        state_r    <= ST_RELEASE;
                        pause_req  <= 1'b0;
                        ioctl_wait <= 1'b0;
                    end else if (pause_ack) begin
                        state_r    <= ST_READY;
                        ioctl_wait <= 1'b0;
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                ST_READY: begin
                    // A falling select outranks a simultaneous read strobe.
                    if (!sel_s) begin
                        state_r    <= ST_RELEASE;
                        pause_req  <= 1'b0;
                        ioctl_wait <= 1'b0;
                    end else if (!pause_ack) begin
                        state_r    <= ST_HOLD;
                        ioctl_wait <= 1'b1;
                    end else if (ioctl_rd && in_range_s) begin
                        state_r    <= ST_FETCH;
                        ram_addr   <= ioctl_addr[AW-1:0];
                        ram_rd     <= 1'b1;
                        ioctl_wait <= 1'b1;
                        cnt_r      <= CW'(RAM_LAT);
                    end else if (ioctl_rd) begin
                        ioctl_din <= oob_byte_s;
                    end else begin
                        state_r <= ST_READY;
                    end
                end
                ST_FETCH: begin
                    if (!sel_s) begin
                        state_r    <= ST_RELEASE;
                        pause_req  <= 1'b0;
                        ioctl_wait <= 1'b0;
                    end else if (cnt_r == {CW{1'b0}}) begin
                        state_r    <= ST_READY;
                        ioctl_din  <= ram_q;
                        ioctl_wait <= 1'b0;
`ifdef UPLOAD_CKSUM_EN
                        sum_r      <= sum_r + ram_q;
`endif
                    end else begin
                        cnt_r <= cnt_r - CW'(1);
                    end
                end
                ST_RELEASE: begin
                    state_r    <= ST_IDLE;
                    pause_req  <= 1'b0;
                    ioctl_wait <= 1'b0;
                    busy       <= 1'b0;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    pause_req  <= 1'b0;
                    ioctl_wait <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule
